inst_loader: RTL
================

// Module: inst_loader
// PURPOSE
//  Writer side of the CPU instruction store: accepts a program as a byte stream over a
//  valid/ready handshake and writes it into the instruction memory read by the fetch unit.
//  Holds the CPU (cpu_hold) until a load completes, then releases it. Reports a running
//  XOR checksum, word count and length error for host-side confirmation.
// PARAMETERS
//  ADDR_W   4   instruction memory address width; DEPTH = 2**ADDR_W entries
//  DATA_W   8   instruction width, matches the 8-bit instruction word
// PORTS
//  clk          in   1         single clock; all logic on rising edge
//  reset        in   1         synchronous, active-high
//  start        in   1         1-cycle pulse: begin load of `length` words
//  length       in   ADDR_W+1  words to load, sampled on accepted start
//  in_valid     in   1         in_data valid
//  in_data      in   DATA_W    instruction byte
//  in_ready     out  1         loader accepts in_data this cycle
//  imem_we      out  1         instruction memory write strobe
//  imem_addr    out  ADDR_W    write address
//  imem_wdata   out  DATA_W    write data
//  busy         out  1         state == LOAD
//  done         out  1         state == DONE (level)
//  len_err      out  1         requested length exceeded DEPTH (sticky until next start)
//  count        out  ADDR_W+1  words written in current/last load
//  checksum     out  DATA_W    XOR of all bytes accepted in current/last load
//  cpu_hold     out  1         1 = keep CPU stalled; 0 only in DONE
// BEHAVIOUR
//  - States: IDLE, LOAD, DONE. All outputs registered or decoded from registered state.
//  - Reset (sync, any state incl. mid-load): state=IDLE; imem_we=0, imem_addr=0,
//    imem_wdata=0, count=0, checksum=0, len_err=0, in_ready=0, busy=0, done=0, cpu_hold=1.
//  - start accepted in IDLE or DONE only; ignored in LOAD. On accept: count=0, checksum=0,
//    len_err=(length>DEPTH), target=min(length,DEPTH).
//    target==0 -> DONE next cycle, no writes. Else -> LOAD.
//  - in_ready = (state==LOAD). Transfer occurs when in_valid && in_ready on a rising edge.
//  - On transfer: next cycle imem_we=1, imem_addr=count[ADDR_W-1:0], imem_wdata=in_data;
//    count+=1, checksum^=in_data. Write latency 1 cycle after transfer. imem_we=0 on any
//    cycle without a transfer on the previous edge.
//  - Transfer of word target-1 moves state to DONE on the same edge; in_ready drops the
//    next cycle, so no transfer beyond target. Back-to-back transfers: 1 word/cycle.
//  - in_valid bubbles: loader waits indefinitely in LOAD, no timeout; count/addr unchanged.
//  - in_valid while not LOAD: ignored, no write, no state change.
//  - Address never wraps: max address DEPTH-1 because target<=DEPTH.
//  - DONE: done=1, cpu_hold=0, count/checksum/len_err hold final values until next start.
//    Accepted start in DONE re-asserts cpu_hold=1 on the next cycle (reload).
//  - start coincident with reset: reset wins.
// TESTING
//  1. reset; start length=4; stream 0x11,0x22,0x44,0x88 back-to-back -> writes addr0..3,
//     each imem_we 1 cycle after transfer; done=1, count=4, checksum=0xFF, cpu_hold=0.
//  2. length=3 with in_valid low 2 cycles between bytes -> exactly 3 writes, addr 0,1,2,
//     no write on bubble cycles, in_ready high throughout LOAD.
//  3. start length=0 -> DONE next cycle, imem_we never asserted, count=0, checksum=0.
//  4. start length=20 (DEPTH=16) -> len_err=1, 16 writes addr0..15, done, in_ready=0 after 16th.
//  5. reset asserted after 2 of 5 words -> next cycle IDLE, imem_we=0, count=0, cpu_hold=1;
//     in_valid held high afterwards causes no writes.
//  6. start pulse during LOAD (length=6 on second pulse) -> ignored; load of original 3 words
//     completes; then start in DONE, length=2 -> cpu_hold=1, count=0, fresh 2-word load.

Source files
------------

// File: rtl/inst_loader.sv
// Instruction store loader: takes a program as a valid/ready byte stream, writes it into
// instruction memory, and holds the CPU until the requested number of words has landed.
module inst_loader #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_length,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [DATA_W-1:0] o_imem_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_len_err,
    output logic [ADDR_W:0]   o_count,
    output logic [DATA_W-1:0] o_checksum,
    output logic              o_cpu_hold
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DepthL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone
    } state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W:0]     r_target;
    logic [DATA_W-1:0]   r_checksum;
    logic                r_len_err;

    logic                w_start_ok;
    logic                w_xfer;
    logic [ADDR_W:0]     w_target_new;
    logic [ADDR_W:0]     w_count_inc;

    always_comb begin
        w_start_ok   = i_start && (r_state != StLoad);
        w_xfer       = i_in_valid && (r_state == StLoad);
        w_target_new = (i_length > DepthL) ? DepthL : i_length;
        w_count_inc  = r_count + 1'b1;
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StDone: begin
                if (w_start_ok) begin
                    w_state_next = (w_target_new == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                // Final word moves to DONE on the same edge so in_ready drops next cycle.
                if (w_xfer && (w_count_inc == r_target)) begin
                    w_state_next = StDone;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_count    <= '0;
            r_target   <= '0;
            r_checksum <= '0;
            r_len_err  <= 1'b0;
        end else begin
            r_we <= w_xfer;
            if (w_start_ok) begin
                r_count    <= '0;
                r_checksum <= '0;
                r_len_err  <= (i_length > DepthL);
                r_target   <= w_target_new;
            end else if (w_xfer) begin
                r_addr     <= r_count[ADDR_W-1:0];
                r_wdata    <= i_in_data;
                r_count    <= w_count_inc;
                r_checksum <= r_checksum ^ i_in_data;
            end
        end
    end

    assign o_in_ready   = (r_state == StLoad);
    assign o_busy       = (r_state == StLoad);
    assign o_done       = (r_state == StDone);
    assign o_cpu_hold   = (r_state != StDone);
    assign o_imem_we    = r_we;
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = r_wdata;
    assign o_count      = r_count;
    assign o_checksum   = r_checksum;
    assign o_len_err    = r_len_err;

endmodule
